// File: rtl/sys_ctrl_rx_cmd.sv
// Command-frame decoder behind the UART receiver. It assembles RF write, RF read
// and ALU frames from the byte stream and issues one-cycle strobes to the RF and ALU.
module sys_ctrl_rx_cmd #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int FUN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_d_vld,
  input  logic [DATA_W-1:0] rx_p_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              alu_en,
  output logic [FUN_W-1:0]  alu_fun,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] CMD_WR   = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD   = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_ALU  = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_FUN  = DATA_W'(8'hDD);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [FUN_W-1:0]   fun_q, fun_d;
  logic               wr_q, wr_d, rd_q, rd_d, alu_q, alu_d, err_q, err_d, busy_q;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_addr_d = hold_addr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fun_d       = fun_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    alu_d       = 1'b0;
    err_d       = 1'b0;

    if (rx_d_vld) begin
      // A byte always beats a timeout expiring in the same cycle.
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if      (rx_p_data == CMD_WR)  state_d = WR_ADDR;
          else if (rx_p_data == CMD_RD)  state_d = RD_ADDR;
          else if (rx_p_data == CMD_ALU) state_d = ALU_A;
          else if (rx_p_data == CMD_FUN) state_d = ALU_FUN;
          else                           err_d   = 1'b1;
        end
        WR_ADDR: begin
          hold_addr_d = rx_p_data[ADDR_W-1:0];
          state_d     = WR_DATA;
        end
        WR_DATA: begin
          wr_d    = 1'b1;
          addr_d  = hold_addr_q;
          wdata_d = rx_p_data;
          state_d = IDLE;
        end
        RD_ADDR: begin
          rd_d    = 1'b1;
          addr_d  = rx_p_data[ADDR_W-1:0];
          state_d = IDLE;
        end
        ALU_A: begin
          wr_d    = 1'b1;
          addr_d  = '0;
          wdata_d = rx_p_data;
          state_d = ALU_B;
        end
        ALU_B: begin
          wr_d    = 1'b1;
          addr_d  = ADDR_W'(1);
          wdata_d = rx_p_data;
          state_d = ALU_FUN;
        end
        ALU_FUN: begin
          alu_d   = 1'b1;
          fun_d   = rx_p_data[FUN_W-1:0];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_addr_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fun_q       <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      alu_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_addr_q <= hold_addr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fun_q       <= fun_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      err_q       <= err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign rf_wr_en   = wr_q;
  assign rf_rd_en   = rd_q;
  assign rf_addr    = addr_q;
  assign rf_wr_data = wdata_q;
  assign alu_en     = alu_q;
  assign alu_fun    = fun_q;
  assign busy       = busy_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
// Bench for sys_ctrl_rx_cmd: directed frame scenarios with literal expectations, then
// randomized byte streams compared every cycle against a frame-level reference model.
module tb_sys_ctrl_rx_cmd;

  localparam int TO = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_d_vld = 1'b0;
  logic [7:0] rx_p_data = 8'h00;
  logic       rf_wr_en, rf_rd_en, alu_en, busy, frame_err;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr = 0, n_rd = 0, n_alu = 0, n_err = 0;

  sys_ctrl_rx_cmd #(.DATA_W(8), .ADDR_W(4), .FUN_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_d_vld(rx_d_vld), .rx_p_data(rx_p_data),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the command byte of the frame in progress and how many
  // bytes of it have arrived; the expected outputs are what the frame rules dictate.
  int         m_cmd = 0;
  int         m_idx = 0;
  int         m_silent = 0;
  logic [3:0] m_hold = '0;
  logic       e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0, e_busy = 0;
  logic [3:0] e_addr = '0, e_fun = '0;
  logic [7:0] e_wdata = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cmd = 0; m_idx = 0; m_silent = 0; m_hold = '0;
      e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0; e_busy = 0;
      e_addr = '0; e_fun = '0; e_wdata = '0;
    end else begin
      e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
      if (rx_d_vld) begin
        m_silent = 0;
        if (m_cmd == 0) begin
          if (rx_p_data inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
            m_cmd = int'(rx_p_data);
            m_idx = 0;
          end else e_err = 1;
        end else begin
          m_idx++;
          case (m_cmd)
            'hAA: if (m_idx == 1) m_hold = rx_p_data[3:0];
                  else begin e_wr = 1; e_addr = m_hold; e_wdata = rx_p_data; m_cmd = 0; end
            'hBB: begin e_rd = 1; e_addr = rx_p_data[3:0]; m_cmd = 0; end
            'hCC: if (m_idx < 3) begin e_wr = 1; e_addr = 4'(m_idx - 1); e_wdata = rx_p_data; end
                  else begin e_alu = 1; e_fun = rx_p_data[3:0]; m_cmd = 0; end
            default: begin e_alu = 1; e_fun = rx_p_data[3:0]; m_cmd = 0; end
          endcase
        end
      end else if (m_cmd != 0) begin
        m_silent++;
        if (m_silent == TO) begin e_err = 1; m_cmd = 0; m_silent = 0; end
      end
      e_busy = (m_cmd != 0);
    end
  end

  // Compare process and pulse counters, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    check("outputs",
          {11'd0, rf_wr_en, rf_rd_en, alu_en, frame_err, busy, rf_addr, rf_wr_data, alu_fun},
          {11'd0, e_wr, e_rd, e_alu, e_err, e_busy, e_addr, e_wdata, e_fun});
    if (!rst) begin
      n_wr  += int'(rf_wr_en);
      n_rd  += int'(rf_rd_en);
      n_alu += int'(alu_en);
      n_err += int'(frame_err);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_d_vld  = 1'b1;
    rx_p_data = b;
    @(negedge clk);
    rx_d_vld  = 1'b0;
    rx_p_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  int base_wr, base_rd, base_alu, base_err, gap;
  logic [7:0] b;

  initial begin
    do_reset();
    check("reset_outputs", {rf_wr_en, rf_rd_en, alu_en, frame_err, busy, rf_addr, rf_wr_data, alu_fun}, '0);

    // RF write frame
    base_wr = n_wr;
    send(8'hAA);
    check("wr_busy_mid", busy, 1);
    send(8'h05); send(8'h3C);
    check("wr_strobe", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h5, 8'h3C});
    check("wr_busy_end", busy, 0);
    idle(1);
    check("wr_one_cycle", rf_wr_en, 0);
    check("wr_pulse_count", n_wr - base_wr, 1);

    // RF read frame, upper address bits dropped
    base_wr = n_wr;
    send(8'hBB); send(8'hF2);
    check("rd_strobe", {rf_rd_en, rf_addr}, {1'b1, 4'h2});
    idle(1);
    check("rd_no_wr", n_wr - base_wr, 0);

    // ALU frame with operands, then without
    send(8'hCC); send(8'h12);
    check("alu_opa", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h0, 8'h12});
    send(8'h34);
    check("alu_opb", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h1, 8'h34});
    send(8'h01);
    check("alu_fun1", {alu_en, alu_fun, rf_wr_en}, {1'b1, 4'h1, 1'b0});
    base_wr = n_wr; base_alu = n_alu;
    send(8'hDD); send(8'h07);
    check("alu_fun7", {alu_en, alu_fun}, {1'b1, 4'h7});
    idle(1);
    check("dd_no_wr", n_wr - base_wr, 0);
    check("dd_alu_count", n_alu - base_alu, 1);

    // Unknown command, then a timed-out frame, then recovery
    base_wr = n_wr; base_rd = n_rd; base_alu = n_alu; base_err = n_err;
    send(8'h55);
    check("unknown_err", {frame_err, busy}, {1'b1, 1'b0});
    send(8'hAA); send(8'h03);
    idle(TO - 1);
    check("before_expiry", {frame_err, busy}, {1'b0, 1'b1});
    idle(1);
    check("timeout_err", {frame_err, busy}, {1'b1, 1'b0});
    idle(1);
    check("timeout_no_strobe", (n_wr - base_wr) + (n_rd - base_rd) + (n_alu - base_alu), 0);
    check("err_count", n_err - base_err, 2);
    send(8'hAA); send(8'h01); send(8'hFF);
    check("after_timeout_wr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h1, 8'hFF});

    // Byte arriving on the expiry cycle wins (and a command value mid-frame is data)
    send(8'hAA); send(8'h04);
    idle(TO - 1);
    send(8'hDD);
    check("expiry_byte_wins", {rf_wr_en, frame_err, rf_addr, rf_wr_data}, {1'b1, 1'b0, 4'h4, 8'hDD});

    // Reset mid-frame clears outputs immediately
    send(8'hCC); send(8'h12);
    #2 rst = 1'b1;
    #1 check("rst_async", {rf_wr_en, rf_rd_en, alu_en, frame_err, busy, rf_addr, rf_wr_data, alu_fun}, '0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send(8'hBB); send(8'h09);
    check("rd_after_rst", {rf_rd_en, rf_addr, busy}, {1'b1, 4'h9, 1'b0});

    // Randomized streams with gaps straddling the timeout boundary
    gap = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else if (gap > 0) begin
        gap--;
        idle(1);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 4))
            0: b = 8'hAA;
            1: b = 8'hBB;
            2: b = 8'hCC;
            3: b = 8'hDD;
            default: b = 8'h55;
          endcase
        end else b = 8'($urandom);
        send(b);
        case ($urandom_range(0, 19))
          0, 1, 2, 3, 4:  gap = int'($urandom_range(TO - 2, TO + 1));
          5:              gap = int'($urandom_range(TO + 2, 3 * TO));
          default:        gap = int'($urandom_range(0, 2));
        endcase
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
